apu_sfx_mixer: RTL

Parametrised multi-channel sound-effect generator and mixer for the tapestation APU, and the successor to the fixed three-collision-input APU. Each channel is fired by a one-cycle trigger and latches its own period, volume and mode. It then plays a square, noise or downward-sweep tone under a frame-rate volume decay. Channel outputs are summed and driven out as a glitch-free PWM bit for the audio pin.

---
 rtl/apu_sfx_mixer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/apu_sfx_mixer.sv
// Multi-channel sound-effect generator: square/noise/sweep tones with
// frame-rate volume decay, summed into a registered sample and PWM bit.
module apu_sfx_mixer #(
  parameter  int NUM_CH       = 4,
  parameter  int PERIOD_W     = 12,
  parameter  int VOL_W        = 4,
  parameter  int DECAY_FRAMES = 1,
  localparam int MIX_W        = VOL_W + $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic [NUM_CH-1:0]          trig,
  input  logic [NUM_CH*PERIOD_W-1:0] period_in,
  input  logic [NUM_CH*VOL_W-1:0]    vol_in,
  input  logic [NUM_CH*2-1:0]        mode_in,
  output logic [NUM_CH-1:0]          busy,
  output logic [MIX_W-1:0]           sample_out,
  output logic                       pwm_out
);

  localparam int DW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  typedef enum logic {IDLE, PLAY} st_t;

  st_t                 r_st   [NUM_CH];
  st_t                 w_st   [NUM_CH];
  logic [PERIOD_W-1:0] r_per  [NUM_CH];
  logic [PERIOD_W-1:0] w_per  [NUM_CH];
  logic [PERIOD_W-1:0] r_cnt  [NUM_CH];
  logic [PERIOD_W-1:0] w_cnt  [NUM_CH];
  logic [VOL_W-1:0]    r_vol  [NUM_CH];
  logic [VOL_W-1:0]    w_vol  [NUM_CH];
  logic [DW-1:0]       r_dcnt [NUM_CH];
  logic [DW-1:0]       w_dcnt [NUM_CH];
  logic [14:0]         r_lfsr [NUM_CH];
  logic [14:0]         w_lfsr [NUM_CH];
  logic [1:0]          r_mode [NUM_CH];
  logic [1:0]          w_mode [NUM_CH];
  logic                r_ph   [NUM_CH];
  logic                w_ph   [NUM_CH];

  logic [PERIOD_W-1:0] w_pin;
  logic [PERIOD_W:0]   w_sw;
  logic [MIX_W-1:0]    w_mix;
  logic [MIX_W-1:0]    r_sample;
  logic [MIX_W-1:0]    r_pcnt;
  logic [MIX_W-1:0]    r_cmp;
  logic                r_pwm;

  always_comb begin
    w_st   = r_st;
    w_per  = r_per;
    w_cnt  = r_cnt;
    w_vol  = r_vol;
    w_dcnt = r_dcnt;
    w_lfsr = r_lfsr;
    w_mode = r_mode;
    w_ph   = r_ph;
    w_pin  = '0;
    w_sw   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pin = period_in[i*PERIOD_W +: PERIOD_W];
      if (w_pin == '0) w_pin = PERIOD_W'(1);
      // A trigger wins over any decay or tone step in the same cycle
      if (trig[i]) begin
        w_st[i]   = PLAY;
        w_per[i]  = w_pin;
        w_cnt[i]  = w_pin;
        w_vol[i]  = vol_in[i*VOL_W +: VOL_W];
        w_mode[i] = mode_in[i*2 +: 2];
        w_ph[i]   = 1'b1;
        w_dcnt[i] = '0;
      end else if (r_st[i] == PLAY) begin
        if (r_cnt[i] != '0) begin
          w_cnt[i] = r_cnt[i] - 1'b1;
        end else begin
          w_cnt[i] = r_per[i];
          if (r_mode[i] == 2'b01) begin
            w_lfsr[i] = {r_lfsr[i][13:0],
                         r_lfsr[i][14] ^ r_lfsr[i][13]};
            w_ph[i]   = w_lfsr[i][0];
          end else begin
            w_ph[i] = ~r_ph[i];
          end
        end
        if (frame_tick) begin
          if (r_dcnt[i] == DW'(DECAY_FRAMES - 1)) begin
            w_dcnt[i] = '0;
            if (r_vol[i] != '0) w_vol[i] = r_vol[i] - 1'b1;
            if (r_mode[i] == 2'b10) begin
              w_sw = {1'b0, r_per[i]} +
                     (PERIOD_W+1)'(r_per[i] >> 3);
              w_per[i] = w_sw[PERIOD_W] ? '1 :
                         w_sw[PERIOD_W-1:0];
            end
          end else begin
            w_dcnt[i] = r_dcnt[i] + 1'b1;
          end
        end
        if (w_vol[i] == '0) begin
          w_st[i] = IDLE;
          w_ph[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_mix = '0;
    busy  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (r_st[i] == PLAY);
      if ((r_st[i] == PLAY) && r_ph[i])
        w_mix = w_mix + MIX_W'(r_vol[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_st[i]   <= IDLE;
        r_per[i]  <= '0;
        r_cnt[i]  <= '0;
        r_vol[i]  <= '0;
        r_dcnt[i] <= '0;
        r_lfsr[i] <= 15'h0001;
        r_mode[i] <= '0;
        r_ph[i]   <= 1'b0;
      end
    end else begin
      r_st   <= w_st;
      r_per  <= w_per;
      r_cnt  <= w_cnt;
      r_vol  <= w_vol;
      r_dcnt <= w_dcnt;
      r_lfsr <= w_lfsr;
      r_mode <= w_mode;
      r_ph   <= w_ph;
    end
  end

  // Compare only reloads at the counter wrap so duty never glitches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_pcnt   <= '0;
      r_cmp    <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_sample <= w_mix;
      r_pcnt   <= r_pcnt + 1'b1;
      if (r_pcnt == '1) r_cmp <= r_sample;
      r_pwm    <= (r_pcnt < r_cmp);
    end
  end

  assign sample_out = r_sample;
  assign pwm_out    = r_pwm;

endmodule
